// File: rtl/bist_controller_pkg.sv
// Shared types and sizing helpers for the BIST sequencing controller.
// Optional start edge detection is selected by the BIST_START_EDGE_EN macro (see bist_controller).
package bist_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FINISH,
        DONE
    } state_e;

    localparam int unsigned NCLOCK_DEF  = 650;
    localparam int unsigned NTOGGLE_DEF = 10;

    // Width never drops to zero, so a degenerate NCLOCK of 1 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned seg_len(input int unsigned nclock, input int unsigned ntoggle);
        return nclock / ntoggle;
    endfunction

    localparam int unsigned SEG   = seg_len(NCLOCK_DEF, NTOGGLE_DEF);
    localparam int unsigned CNT_W = cnt_width(NCLOCK_DEF);

endpackage

// File: rtl/bist_cycle_counter.sv
// Run-cycle counter and segment counter for the BIST controller.
// Both counters hold at zero outside a run and raise last_cycle / seg_end strobes.
module bist_cycle_counter
    import bist_controller_pkg::*;
#(
    parameter int unsigned NCLOCK  = NCLOCK_DEF,
    parameter int unsigned NTOGGLE = NTOGGLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_en,
    output logic last_cycle,
    output logic seg_end
);

    localparam int unsigned SEG_LEN = seg_len(NCLOCK, NTOGGLE);
    localparam int unsigned CW      = cnt_width(NCLOCK);
    localparam int unsigned SW      = cnt_width(SEG_LEN);

    localparam logic [CW-1:0] CNT_LAST = CW'(NCLOCK - 1);
    localparam logic [SW-1:0] SEG_LAST = SW'(SEG_LEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] seg_q, seg_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            seg_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            seg_q <= seg_d;
        end
    end

    always_comb begin
        last_cycle = run_en && (cnt_q == CNT_LAST);
        seg_end    = run_en && (seg_q == SEG_LAST);
    end

    // Return to zero on the final count so the next run starts cleanly without wrap.
    always_comb begin
        cnt_d = '0;
        seg_d = '0;
        if (run_en) begin
            if (!last_cycle) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (!seg_end) begin
                seg_d = seg_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bist_controller.sv
// BIST run sequencer: init pulse, NCLOCK running cycles with periodic toggles, finish, sticky bist_end.
// Define BIST_START_EDGE_EN to launch runs only on a rising edge of start.
module bist_controller
    import bist_controller_pkg::*;
#(
    parameter int unsigned NCLOCK  = NCLOCK_DEF,
    parameter int unsigned NTOGGLE = NTOGGLE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic init,
    output logic running,
    output logic toggle,
    output logic finish,
    output logic bist_end
);

    state_e state_q, state_d;
    logic   start_fire;
    logic   last_cycle;
    logic   seg_end;

`ifdef BIST_START_EDGE_EN
    logic start_q, start_d;

    // Resets high so a start already asserted at reset release is not a launch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start_d;
        end
    end

    always_comb begin
        start_d    = start;
        start_fire = start && !start_q;
    end
`else
    always_comb begin
        start_fire = start;
    end
`endif

    bist_cycle_counter #(
        .NCLOCK  (NCLOCK),
        .NTOGGLE (NTOGGLE)
    ) u_cycle_counter (
        .clk        (clk),
        .rst_n      (reset),
        .run_en     (state_q == RUN),
        .last_cycle (last_cycle),
        .seg_end    (seg_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_fire) state_d = INIT;
            INIT:    state_d = RUN;
            RUN:     if (last_cycle) state_d = FINISH;
            FINISH:  state_d = DONE;
            DONE:    if (start_fire) state_d = INIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        init     = (state_q == INIT);
        running  = (state_q == RUN);
        toggle   = (state_q == RUN) && seg_end;
        finish   = (state_q == FINISH);
        bist_end = (state_q == FINISH) || (state_q == DONE);
    end

endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller: each launched run pushes its expected
// pulse counts, and the monitor pops and compares them when finish is seen.
module tb_bist_controller;

    localparam int unsigned NCLOCK  = 650;
    localparam int unsigned NTOGGLE = 10;
    localparam int unsigned SEGL    = NCLOCK / NTOGGLE;

    logic clk;
    logic reset;
    logic start;
    logic init;
    logic running;
    logic toggle;
    logic finish;
    logic bist_end;

    bist_controller #(
        .NCLOCK  (NCLOCK),
        .NTOGGLE (NTOGGLE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .init     (init),
        .running  (running),
        .toggle   (toggle),
        .finish   (finish),
        .bist_end (bist_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned n_init;
        int unsigned n_run;
        int unsigned n_tog;
    } exp_t;

    exp_t sb[$];

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_run();
        exp_t e;
        e.n_init = 1;
        e.n_run  = NCLOCK;
        e.n_tog  = NTOGGLE;
        sb.push_back(e);
    endtask

    // Monitor: accumulates pulses of the current run, compares on finish.
    int unsigned init_seen = 0;
    int unsigned run_idx   = 0;
    int unsigned tog_seen  = 0;
    int unsigned tog_bad   = 0;
    int unsigned first_ok  = 0;
    logic        prev_init = 1'b0;
    logic        prev_run  = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            init_seen = 0; run_idx = 0; tog_seen = 0; tog_bad = 0; first_ok = 0;
            prev_init = 1'b0; prev_run = 1'b0;
        end else begin
            if (init) begin
                init_seen++;
                chk("bist_end_in_init", 32'(bist_end), 0);
            end
            if (running) begin
                if (run_idx == 0) first_ok = 32'(prev_init);
                if (toggle) begin
                    tog_seen++;
                    if ((run_idx % SEGL) != SEGL - 1) tog_bad++;
                end
                run_idx++;
            end else if (toggle) begin
                tog_bad++;
            end
            if (finish) begin
                if (sb.size() == 0) begin
                    chk("unexpected_finish", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("init_count",      init_seen, e.n_init);
                    chk("running_cycles",  run_idx,   e.n_run);
                    chk("toggle_count",    tog_seen,  e.n_tog);
                    chk("toggle_position", tog_bad,   0);
                    chk("init_to_running", first_ok,  1);
                    chk("finish_after_run", 32'(prev_run), 1);
                    chk("bist_end_at_finish", 32'(bist_end), 1);
                end
                init_seen = 0; run_idx = 0; tog_seen = 0; tog_bad = 0; first_ok = 0;
            end
            prev_init = init;
            prev_run  = running;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int unsigned budget);
        for (int unsigned i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk(tag, sb.size(), 0);
    endtask

    function automatic int unsigned outs();
        return 32'({init, running, toggle, finish, bist_end});
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b1;
        #13;
        chk("reset_outputs", outs(), 0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_outputs", outs(), 0);

        // Normal run
        pulse_start();
        push_run();
        chk("init_visible", 32'(init), 1);
        wait_drain("run1_drain", NCLOCK + 20);
        chk("run1_bist_end", 32'(bist_end), 1);
        chk("run1_running_low", 32'(running), 0);

        // Consecutive run: bist_end clears in INIT
        pulse_start();
        push_run();
        chk("run2_init", 32'(init), 1);
        chk("run2_bist_end_clr", 32'(bist_end), 0);
        wait_drain("run2_drain", NCLOCK + 20);
        chk("run2_bist_end", 32'(bist_end), 1);

        // Start during a run is ignored
        pulse_start();
        push_run();
        repeat (2) @(negedge clk);
        pulse_start();
        wait_drain("midstart_drain", NCLOCK + 20);
        chk("midstart_bist_end", 32'(bist_end), 1);

        // Reset mid-run while start rises, released with start still high
        pulse_start();
        push_run();
        repeat (20) @(negedge clk);
        #2;
        reset = 1'b0;
        start = 1'b1;
        #1;
        chk("rst_start_outputs", outs(), 0);
        sb.delete();
        @(negedge clk);
        #3;
        reset = 1'b1;
`ifndef BIST_START_EDGE_EN
        push_run();
`endif
        repeat (2) @(negedge clk);
        start = 1'b0;
`ifdef BIST_START_EDGE_EN
        chk("edge_no_launch", outs(), 0);
        pulse_start();
        push_run();
`endif
        wait_drain("rst_start_drain", NCLOCK + 20);

        // Plain reset 50 ns into a run
        pulse_start();
        push_run();
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_running", 32'(running), 0);
        chk("midrst_toggle",  32'(toggle), 0);
        chk("midrst_bist_end", 32'(bist_end), 0);
        sb.delete();
        #10;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_idle", outs(), 0);
        pulse_start();
        push_run();
        wait_drain("midrst_drain", NCLOCK + 20);

        // Start held high for 2000 cycles
        @(negedge clk);
        start = 1'b1;
        push_run();
`ifndef BIST_START_EDGE_EN
        push_run();
        push_run();
        push_run();
`endif
        repeat (2000) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_drain("hold_drain", 3 * NCLOCK);
        chk("hold_bist_end", 32'(bist_end), 1);
        repeat (5) @(negedge clk);
        chk("final_quiet", 32'({init, running, finish}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Sequencing controller for a built-in self-test (BIST) run.
- On a start request it issues a one-cycle init, then holds running for NCLOCK clock cycles while emitting periodic one-cycle toggle pulses.
- It then pulses finish and raises a sticky bist_end flag.
- Sits between the top-level test request and the pattern generator / signature analyser datapath.

Parameters:
- NCLOCK, 650: number of clock cycles running is held high per run (must be ≥ NTOGGLE).
- NTOGGLE, 10: number of toggle pulses per run. NCLOCK must be an exact multiple of NTOGGLE; segment length SEG = NCLOCK/NTOGGLE (65 by default).

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled on rising clk
- init  out  1  one-cycle pulse, initialises datapath before the run
- running  out  1  high for exactly NCLOCK consecutive cycles during a run
- toggle  out  1  one-cycle pulse at the end of each SEG-cycle segment
- finish  out  1  one-cycle pulse after the last running cycle
- bist_end  out  1  sticky completion flag

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low. While reset=0, state=IDLE, counters=0 and all outputs=0.
- Outputs are registered and decoded from state only (Moore); there is no combinational path from start.
- States: IDLE, INIT, RUN, FINISH, DONE.
- IDLE: start=1 at a clk edge → INIT.
- INIT: init=1 for exactly one cycle, then → RUN. Cycle counter cleared.
- RUN: running=1. Cycle counter cnt counts 0..NCLOCK-1.
  - toggle=1 in cycles where cnt mod SEG == SEG-1, giving exactly NTOGGLE pulses per run; the last pulse coincides with the last running cycle.
  - When cnt==NCLOCK-1 → FINISH.
- FINISH: finish=1 for one cycle; bist_end set to 1 in this cycle; → DONE.
- DONE: bist_end stays 1. start=1 → INIT; bist_end clears in the INIT cycle.
- Latency: start sampled at edge k → init high in cycle k+1 → running high in cycles k+2 .. k+NCLOCK+1 → finish high in cycle k+NCLOCK+2.
- start during INIT, RUN or FINISH is ignored. The run is not restarted or extended.
- start held high continuously: a new run launches from DONE (or IDLE) each time those states are reached (level-sensitive).
- Reset mid-run: asynchronous abort to IDLE with all outputs 0 immediately. A later start performs a complete fresh run.
- start high while reset=0: ignored. start still high on the first edge after reset release launches a run.
- Counter width: $clog2(NCLOCK); no wrap-around occurs within a run.

Optional Feature:
- Macro BIST_START_EDGE_EN.
- Defined: start is registered and only a rising edge (0→1) launches a run from IDLE/DONE; a level held high launches just one run. The edge detector register resets to 1, so a start already high at reset release does not launch.
- Undefined: level-sensitive start exactly as in Behaviour.

Decomposition:
- Package bist_controller_pkg holds:
  - state enum (IDLE, INIT, RUN, FINISH, DONE)
  - localparam helpers: SEG = NCLOCK/NTOGGLE, CNT_W = $clog2(NCLOCK)
- One natural sub-module: bist_cycle_counter.
  - Function: run-cycle counter plus segment counter.
  - Outputs: last_cycle and seg_end strobes.
  - The FSM in bist_controller instantiates it.

Test Plan:
- Normal run: reset low 13 ns then high, start pulse 13 ns; wait 7000 ns → 10 toggle rising edges, running counted high on exactly 650 clk edges, one init pulse, one finish pulse, bist_end=1 afterwards.
- Consecutive runs: after first run completes (bist_end=1), a second start pulse → bist_end drops, init pulse, new 650-cycle run with 10 toggles, bist_end re-asserts.
- Mid-run start: start pulse, then another start pulse 30 ns later → ignored; running still totals 650 cycles from the first start and finish occurs exactly once.
- Reset with start: reset asserted mid-run while start goes high, then reset released before start drops → outputs 0 during reset; the start sampled after release yields exactly one full run (650 running cycles, 10 toggles).
- Mid-run reset: reset asserted 50 ns into a run for 13 ns → running/toggle drop to 0 asynchronously; bist_end stays 0; a subsequent start gives a complete 650-cycle run.
- With BIST_START_EDGE_EN: start held high for 2000 cycles → exactly one run; without the macro → back-to-back runs.
